// File: rtl/jtopl_wrseq.sv
// jtopl_wrseq -- host-side write sequencer and arbiter for the OPL register file.
//
// Accepts register writes from two requesters, arbitrates between them and
// turns each accepted write into the two-step OPL bus protocol: an address-port
// strobe, a wait of ADDR_WAIT cen pulses, a data-port strobe, then a wait of
// DATA_WAIT cen pulses before the next write may be accepted.
//
// Parameters:
//   ADDR_WAIT  cen pulses after the address-port write (1..127)
//   DATA_WAIT  cen pulses after the data-port write (1..127)
//
// Ports:
//   rst                 synchronous reset, active-high
//   clk                 clock, rising edge
//   cen                 master-clock enable, only advances the wait counter
//   reqN_valid/reg/val  requester N write request (N = 0, 1)
//   reqN_ready          requester N accepted this cycle (combinational, IDLE only)
//   opl_write           one-cycle write strobe to the register map
//   opl_addr            0 = address port, 1 = data port (holds last value)
//   opl_din             bus data to the register map (holds last value)
//   busy                a transaction is in progress
//   gnt                 requester owning the current or last transaction
//
// Build option:
//   JTOPL_WRSEQ_RR_EN   when defined, ties are broken round-robin instead of
//                       by fixed priority to requester 0.

module jtopl_wrseq #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       req0_valid,
  input  logic [7:0] req0_reg,
  input  logic [7:0] req0_val,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_reg,
  input  logic [7:0] req1_val,
  output logic       req1_ready,
  output logic       opl_write,
  output logic       opl_addr,
  output logic [7:0] opl_din,
  output logic       busy,
  output logic       gnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_AWAIT,
    S_DATA,
    S_DWAIT
  } state_t;

  localparam logic [6:0] LP_AW = 7'(ADDR_WAIT);
  localparam logic [6:0] LP_DW = 7'(DATA_WAIT);

  state_t     r_state;
  state_t     w_next;
  logic [6:0] r_cnt;
  logic [7:0] r_val;
  logic [7:0] r_din;
  logic       r_addr;
  logic       r_gnt;
  logic       w_take;
  logic       w_sel;      // 1 selects requester 1
  logic       w_wait_done;
`ifdef JTOPL_WRSEQ_RR_EN
  logic       r_ptr;      // requester preferred on the next tie
`endif

  // Arbitration: only meaningful while IDLE.
  always_comb begin
    w_take = req0_valid | req1_valid;
`ifdef JTOPL_WRSEQ_RR_EN
    if (req0_valid && req1_valid) w_sel = r_ptr;
    else                          w_sel = req1_valid;
`else
    w_sel = ~req0_valid;
`endif
  end

  // The wait ends on the cen pulse that would take the counter from 1 to 0.
  assign w_wait_done = cen && (r_cnt == 7'd1);

  always_comb begin
    w_next     = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          w_next     = S_ADDR;
          req0_ready = ~w_sel;
          req1_ready = w_sel;
        end
      end
      S_ADDR:  w_next = S_AWAIT;
      S_AWAIT: if (w_wait_done) w_next = S_DATA;
      S_DATA:  w_next = S_DWAIT;
      S_DWAIT: if (w_wait_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 7'd0;
      r_val   <= 8'd0;
      r_din   <= 8'd0;
      r_addr  <= 1'b0;
      r_gnt   <= 1'b0;
`ifdef JTOPL_WRSEQ_RR_EN
      r_ptr   <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          // The register number goes straight onto the bus register so it is
          // presented during the ADDR cycle; the value waits in r_val.
          if (w_take) begin
            r_din  <= w_sel ? req1_reg : req0_reg;
            r_val  <= w_sel ? req1_val : req0_val;
            r_addr <= 1'b0;
            r_gnt  <= w_sel;
`ifdef JTOPL_WRSEQ_RR_EN
            r_ptr  <= ~w_sel;
`endif
          end
        end
        S_ADDR: r_cnt <= LP_AW;
        S_AWAIT: begin
          if (cen) r_cnt <= r_cnt - 7'd1;
          if (w_wait_done) begin
            r_din  <= r_val;
            r_addr <= 1'b1;
          end
        end
        S_DATA: r_cnt <= LP_DW;
        S_DWAIT: if (cen) r_cnt <= r_cnt - 7'd1;
        default: ;
      endcase
    end
  end

  assign opl_write = (r_state == S_ADDR) || (r_state == S_DATA);
  assign opl_addr  = r_addr;
  assign opl_din   = r_din;
  assign busy      = (r_state != S_IDLE);
  assign gnt       = r_gnt;

endmodule

// File: tb/tb_jtopl_wrseq.sv
// tb_jtopl_wrseq -- randomized scoreboard bench for jtopl_wrseq.
//
// The cen pattern is generated up front, so the reference model can compute
// every strobe cycle of a transaction at acceptance time by counting cen
// pulses.  A driver issues requests; a monitor predicts acceptance, queues
// the expected strobes and compares them as the DUT produces them.

module tb_jtopl_wrseq;
  localparam int AW = 12;
  localparam int DW = 84;
  localparam int NC = 14500;

  typedef struct {
    int         cyc;
    logic       a;
    logic [7:0] d;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0] req0_reg = 8'd0, req0_val = 8'd0, req1_reg = 8'd0, req1_val = 8'd0;
  logic       req0_ready, req1_ready, opl_write, opl_addr, busy, gnt;
  logic [7:0] opl_din;

  bit  cen_pat [NC];
  ev_t sbq [$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  jtopl_wrseq #(.ADDR_WAIT(AW), .DATA_WAIT(DW)) dut (
    .rst(rst), .clk(clk), .cen(cen),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_val(req0_val), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_val(req1_val), .req1_ready(req1_ready),
    .opl_write(opl_write), .opl_addr(opl_addr), .opl_din(opl_din),
    .busy(busy), .gnt(gnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Cycle of the n-th cen pulse at or after cycle 'start'.
  function automatic int nth(input int start, input int n);
    int k = 0;
    for (int c = start; c < NC; c++) begin
      if (cen_pat[c]) begin
        k++;
        if (k == n) return c;
      end
    end
    return NC;
  endfunction

  // Driver
  initial begin
    bit   p0 = 0, p1 = 0, done0 = 0;
    logic a0 = 0, a1 = 0;
    int   rst_cd = 0;
    for (int c = 0; c < NC; c++) begin
      if (c < 300)        cen_pat[c] = 1'b1;
      else if (c < 2000)  cen_pat[c] = (c % 4 == 0);
      else if (c < 12000) cen_pat[c] = 1'($urandom_range(0, 1));
      else                cen_pat[c] = 1'b1;
    end
    while (cyc < NC - 100) begin
      @(posedge clk); #1;
      if (a0) p0 = 0;
      if (a1) p1 = 0;
      cen = cen_pat[cyc];
      rst = (cyc < 5);
      if (rst_cd == 1) rst = 1'b1;
      if (rst_cd > 0) rst_cd--;
      if (cyc >= 14000) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else if (cyc < 300) begin
        if (cyc >= 10 && !done0 && !p0) begin
          p0 = 1; done0 = 1; req0_reg = 8'hA0; req0_val = 8'h41;
        end
        req0_valid = p0;
        req1_valid = 1'b0;
      end else if (cyc < 2000) begin
        if (!p0) begin p0 = 1; req0_reg = 8'($urandom); req0_val = 8'($urandom); end
        if (!p1) begin p1 = 1; req1_reg = 8'($urandom); req1_val = 8'($urandom); end
        req0_valid = p0;
        req1_valid = p1;
      end else begin
        int rate = (cyc < 12000) ? 7 : 1;
        if (!p0 && $urandom_range(0, rate) == 0) begin
          p0 = 1; req0_reg = 8'($urandom); req0_val = 8'($urandom);
        end
        if (!p1 && $urandom_range(0, rate) == 0) begin
          p1 = 1; req1_reg = 8'($urandom); req1_val = 8'($urandom);
        end
        req0_valid = p0 && ($urandom_range(0, 9) != 0);
        req1_valid = p1 && ($urandom_range(0, 9) != 0);
        // Payload may change while valid is low, or while the sequencer is busy.
        if (p0 && $urandom_range(0, 3) == 0) begin req0_reg = 8'($urandom); req0_val = 8'($urandom); end
        if (p1 && $urandom_range(0, 3) == 0) begin req1_reg = 8'($urandom); req1_val = 8'($urandom); end
      end
      if (rst) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      @(negedge clk);
      a0 = req0_ready;
      a1 = req1_ready;
      if (cyc >= 12000 && cyc < 14000 && opl_write && !opl_addr && rst_cd == 0) rst_cd = 3;
    end
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor and reference model
  initial begin
    ev_t        e;
    int         idle_at = 0;
    logic       m_gnt = 1'b0, m_addr = 1'b0;
    logic [7:0] m_din = 8'd0;
    int         t0 = -1;
    int         meas = 0, pc = 0;
    logic       ex_busy, ex_acc, win;
    int         a, d, i;
`ifdef JTOPL_WRSEQ_RR_EN
    logic       m_ptr = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        ex_busy = (cyc < idle_at);
        ex_acc  = !ex_busy && (req0_valid || req1_valid);
`ifdef JTOPL_WRSEQ_RR_EN
        win = (req0_valid && req1_valid) ? m_ptr : req1_valid;
`else
        win = !req0_valid;
`endif
        chk("req0_ready", int'(req0_ready), int'(ex_acc && !win));
        chk("req1_ready", int'(req1_ready), int'(ex_acc && win));
        chk("busy", int'(busy), int'(ex_busy));
        chk("gnt", int'(gnt), int'(m_gnt));

        if (opl_write) begin
          if (sbq.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("strobe_cycle", cyc, e.cyc);
            m_addr = e.a;
            m_din  = e.d;
          end
        end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
          e = sbq.pop_front();
          chk("missing_strobe", 0, 1);
          m_addr = e.a;
          m_din  = e.d;
        end
        chk("opl_addr", int'(opl_addr), int'(m_addr));
        chk("opl_din", int'(opl_din), int'(m_din));

        if (t0 > 0) begin
          if (cyc == t0 + 1) begin
            chk("single_astrobe", int'({opl_write, opl_addr, opl_din}), int'({2'b10, 8'hA0}));
          end
          if (cyc == t0 + 14) begin
            chk("single_dstrobe", int'({opl_write, opl_addr, opl_din}), int'({2'b11, 8'h41}));
          end
          if (cyc == t0 + 98) chk("single_busy_hi", int'(busy), 1);
          if (cyc == t0 + 99) chk("single_busy_lo", int'(busy), 0);
        end

        if (opl_write && !opl_addr) begin
          meas = 1; pc = 0;
        end else if (meas == 1) begin
          if (opl_write) begin
            chk("await_pulses", pc, AW);
            meas = 2; pc = 0;
          end else pc += int'(cen);
        end else if (meas == 2) begin
          if (!busy) begin
            chk("dwait_pulses", pc, DW);
            meas = 0;
          end else pc += int'(cen);
        end

        if (ex_acc) begin
          if (cyc < 300 && t0 < 0) t0 = cyc;
          a = cyc + 1;
          d = nth(a + 1, AW) + 1;
          i = nth(d + 1, DW) + 1;
          e.cyc = a; e.a = 1'b0; e.d = win ? req1_reg : req0_reg;
          sbq.push_back(e);
          e.cyc = d; e.a = 1'b1; e.d = win ? req1_val : req0_val;
          sbq.push_back(e);
          idle_at = i;
          m_gnt   = win;
`ifdef JTOPL_WRSEQ_RR_EN
          m_ptr   = !win;
`endif
        end

        if (rst) begin
          sbq.delete();
          idle_at = cyc + 1;
          m_gnt   = 1'b0;
          m_addr  = 1'b0;
          m_din   = 8'd0;
          meas    = 0;
`ifdef JTOPL_WRSEQ_RR_EN
          m_ptr   = 1'b0;
`endif
        end
      end
    end
  end

endmodule
